// File: rtl/instr_sequencer.sv
// Instruction issuer: streams a preloaded program onto the 13-bit instruction bus
// with valid/ready, inserting bubbles after each mul. Optional macro: ISSUE_STATS_EN.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int MUL_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [12:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          instr_ready,
  output logic [12:0]   instr,
  output logic          instr_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]   stat_add,
  output logic [15:0]   stat_mul,
  output logic [15:0]   stat_load,
  output logic [15:0]   stat_store
`endif
);

  localparam int GW = (MUL_GAP > 1) ? $clog2(MUL_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((MUL_GAP > 0) ? MUL_GAP - 1 : 0);
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [12:0]   buf_q [DEPTH];

  logic          xfer;
  logic          last;
  logic [AW-1:0] pc_next;

  assign xfer    = valid_q & instr_ready;
  assign last    = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign pc_next = pc_q + AW'(1);

  // Buffer is storage only, never reset; read at start sees pre-write contents.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && prog_we) begin
      buf_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    len_d   = len_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (prog_len != '0) begin
            len_d   = prog_len;
            instr_d = buf_q[0];
            pc_d    = '0;
            valid_d = 1'b1;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (instr_q[12:11] == OP_MUL && MUL_GAP > 0) begin
            valid_d = 1'b0;
            gap_d   = GAP_INIT;
            state_d = GAP;
          end else begin
            instr_d = buf_q[pc_next];
            pc_d    = pc_next;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          instr_d = buf_q[pc_next];
          pc_d    = pc_next;
          valid_d = 1'b1;
          state_d = RUN;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign pc          = pc_q;

`ifdef ISSUE_STATS_EN
  // One saturating counter per opcode, indexed directly by the opcode field.
  logic [3:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (state_q == IDLE && start) begin
      stat_d = '0;
    end else if (xfer && stat_q[instr_q[12:11]] != '1) begin
      stat_d[instr_q[12:11]] = stat_q[instr_q[12:11]] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_add   = stat_q[0];
  assign stat_mul   = stat_q[1];
  assign stat_load  = stat_q[2];
  assign stat_store = stat_q[3];
`else
  // Issue statistics not built.
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (DEPTH=16, MUL_GAP=2).
// Observed vector: {instr_valid, instr, pc, busy, done}.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [12:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          instr_ready;
  logic [12:0]   instr;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
`ifdef ISSUE_STATS_EN
  logic [15:0]   stat_add, stat_mul, stat_load, stat_store;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [19:0] got, exp;

  instr_sequencer #(.DEPTH(DEPTH), .MUL_GAP(2)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .instr_ready(instr_ready), .instr(instr), .instr_valid(instr_valid),
    .busy(busy), .done(done), .pc(pc)
`ifdef ISSUE_STATS_EN
    , .stat_add(stat_add), .stat_mul(stat_mul),
    .stat_load(stat_load), .stat_store(stat_store)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [12:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic kick(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    got = {instr_valid, instr, pc, busy, done};
    exp = '0;
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL reset: got %h expected %h", got, exp); end
    rst = 1'b1;
    step();
  endtask

  task automatic load_three();
    load(4'd0, 13'h0000);
    load(4'd1, 13'h1000);
    load(4'd2, 13'h1A05);
  endtask

  task automatic test_stream();
    logic [12:0] prog [3];
    prog[0] = 13'h0000; prog[1] = 13'h1000; prog[2] = 13'h1A05;
    load_three();
    instr_ready = 1'b1;
    kick(5'd3);
    for (int i = 0; i < 3; i++) begin
      got = {instr_valid, instr, pc, busy, done};
      exp = {1'b1, prog[i], AW'(i), 1'b1, 1'b0};
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL stream[%0d]: got %h expected %h", i, got, exp); end
      step();
    end
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b0, 13'h1A05, 4'd2, 1'b0, 1'b1};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL stream_done: got %h expected %h", got, exp); end
    step();
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL stream_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mul_gap();
    load(4'd0, 13'h0800);
    load(4'd1, 13'h0000);
    instr_ready = 1'b1;
    kick(5'd2);
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b1, 13'h0800, 4'd0, 1'b1, 1'b0};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL mul_present: got %h expected %h", got, exp); end
    for (int i = 0; i < 2; i++) begin
      step();
      got = {instr_valid, instr, pc, busy, done};
      exp = {1'b0, 13'h0800, 4'd0, 1'b1, 1'b0};
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL mul_gap[%0d]: got %h expected %h", i, got, exp); end
    end
    step();
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b1, 13'h0000, 4'd1, 1'b1, 1'b0};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL mul_next: got %h expected %h", got, exp); end
    step();
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b0, 13'h0000, 4'd1, 1'b0, 1'b1};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL mul_done: got %h expected %h", got, exp); end
`ifdef ISSUE_STATS_EN
    nvec++;
    if ({stat_add, stat_mul, stat_load, stat_store} !== {16'd1, 16'd1, 16'd0, 16'd0}) begin
      nerr++;
      $display("FAIL mul_stats: got %h/%h/%h/%h expected 1/1/0/0", stat_add, stat_mul, stat_load, stat_store);
    end
`endif
    step();
  endtask

  task automatic test_stall();
    load_three();
    instr_ready = 1'b1;
    kick(5'd3);
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {instr_valid, instr, pc, busy, done};
      exp = {1'b1, 13'h1000, 4'd1, 1'b1, 1'b0};
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, got, exp); end
    end
    instr_ready = 1'b1;
    step();
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b1, 13'h1A05, 4'd2, 1'b1, 1'b0};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL stall_resume: got %h expected %h", got, exp); end
    step();
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b0, 13'h1A05, 4'd2, 1'b0, 1'b1};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL stall_done: got %h expected %h", got, exp); end
    step();
  endtask

  task automatic test_zero_len();
    kick(5'd0);
    nvec++;
    if ({instr_valid, busy, done} !== 3'b001) begin
      nerr++; $display("FAIL zero_len_done: got %b expected 001", {instr_valid, busy, done});
    end
    step();
    nvec++;
    if ({instr_valid, busy, done} !== 3'b000) begin
      nerr++; $display("FAIL zero_len_after: got %b expected 000", {instr_valid, busy, done});
    end
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < DEPTH; i++) load(AW'(i), 13'h0000);
    instr_ready = 1'b1;
    kick(5'd16);
    for (int i = 0; i < DEPTH; i++) begin
      got = {instr_valid, instr, pc, busy, done};
      exp = {1'b1, 13'h0000, AW'(i), 1'b1, 1'b0};
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL full[%0d]: got %h expected %h", i, got, exp); end
      if (i == 5) begin
        start = 1'b1; prog_len = 5'd2;
        prog_we = 1'b1; prog_addr = 4'd9; prog_data = 13'h1FFF;
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      step();
    end
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b0, 13'h0000, 4'd15, 1'b0, 1'b1};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL full_done: got %h expected %h", got, exp); end
    step();
    kick(5'd10);
    repeat (9) step();
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b1, 13'h0000, 4'd9, 1'b1, 1'b0};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL busy_write_ignored: got %h expected %h", got, exp); end
    repeat (2) step();
  endtask

  task automatic test_reset_in_gap();
    load(4'd0, 13'h0800);
    load(4'd1, 13'h0000);
    instr_ready = 1'b1;
    kick(5'd2);
    step();
    nvec++;
    if ({instr_valid, busy} !== 2'b01) begin
      nerr++; $display("FAIL gap_entry: got %b expected 01", {instr_valid, busy});
    end
`ifdef ISSUE_STATS_EN
    nvec++;
    if (stat_mul !== 16'd1) begin nerr++; $display("FAIL stat_mul_pre: got %0d expected 1", stat_mul); end
`endif
    #2 rst = 1'b0;
    #1;
    got = {instr_valid, instr, pc, busy, done};
    exp = '0;
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL async_reset: got %h expected %h", got, exp); end
    step();
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL reset_no_done: got %b expected 0", done); end
    rst = 1'b1;
`ifdef ISSUE_STATS_EN
    nvec++;
    if (stat_mul !== 16'd0) begin nerr++; $display("FAIL stat_mul_post: got %0d expected 0", stat_mul); end
`endif
    step();
    kick(5'd2);
    got = {instr_valid, instr, pc, busy, done};
    exp = {1'b1, 13'h0800, 4'd0, 1'b1, 1'b0};
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL restart: got %h expected %h", got, exp); end
    repeat (4) step();
    nvec++;
    if ({instr_valid, pc, busy, done} !== {1'b0, 4'd1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL restart_done: got %b expected 0000101", {instr_valid, pc, busy, done});
    end
  endtask

  initial begin
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_mul_gap();
    test_stall();
    test_zero_len();
    test_full_depth();
    test_reset_in_gap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
